// File: rtl/AESDefinitions.sv
// Shared AES types, the serial MixColumns FSM states, and GF(2^8) helpers
// used by the iterative AES datapath.
package AESDefinitions;

  typedef logic [127:0] aesState_t;
  typedef logic [31:0]  aesColumn_t;
  typedef logic [7:0]   aesByte_t;

  // Reduction constant for the AES field polynomial x^8 + x^4 + x^3 + x + 1
  localparam aesByte_t GF_REDUCE = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mixColState_t;

  function automatic aesByte_t xtime(input aesByte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column.
// Byte 0 of the column sits in bits [31:24].
module mix_column_word
  import AESDefinitions::*;
(
  input  aesColumn_t i_column,
  input  logic       i_inverse,
  output aesColumn_t o_column
);

  aesByte_t w_s  [4];
  aesByte_t w_x2 [4];
  aesByte_t w_x4 [4];
  aesByte_t w_x8 [4];
  aesByte_t w_m3 [4];
  aesByte_t w_m9 [4];
  aesByte_t w_mB [4];
  aesByte_t w_mD [4];
  aesByte_t w_mE [4];
  aesByte_t w_fwd[4];
  aesByte_t w_inv[4];

  // Every product is built from the doubling chain x2/x4/x8 plus XOR
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign w_s[i]  = i_column[31-8*i -: 8];
    assign w_x2[i] = xtime(w_s[i]);
    assign w_x4[i] = xtime(w_x2[i]);
    assign w_x8[i] = xtime(w_x4[i]);
    assign w_m3[i] = w_x2[i] ^ w_s[i];
    assign w_m9[i] = w_x8[i] ^ w_s[i];
    assign w_mB[i] = w_x8[i] ^ w_x2[i] ^ w_s[i];
    assign w_mD[i] = w_x8[i] ^ w_x4[i] ^ w_s[i];
    assign w_mE[i] = w_x8[i] ^ w_x4[i] ^ w_x2[i];

    assign w_fwd[i] = w_x2[i] ^ w_m3[(i+1)%4] ^ w_s[(i+2)%4] ^ w_s[(i+3)%4];
    assign w_inv[i] = w_mE[i] ^ w_mB[(i+1)%4] ^ w_mD[(i+2)%4] ^ w_m9[(i+3)%4];

    assign o_column[31-8*i -: 8] = i_inverse ? w_inv[i] : w_fwd[i];
  end

endmodule

// File: rtl/mix_columns_serial.sv
// Column-serial MixColumns / InvMixColumns engine: accepts a 128-bit state,
// transforms one column per clock, then holds the result until consumed.
module mix_columns_serial
  import AESDefinitions::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      in_valid,
  output logic      in_ready,
  input  aesState_t in_state,
  input  logic      in_inverse,
  output logic      out_valid,
  input  logic      out_ready,
  output aesState_t out_state
);

  mixColState_t r_state;
  aesState_t    r_work;
  aesState_t    r_outState;
  logic         r_mode;
  logic [1:0]   r_col;
  logic         r_inReady;
  logic         r_outValid;

  aesColumn_t   w_colIn;
  aesColumn_t   w_colOut;
  aesState_t    w_workNext;

  always_comb begin
    w_colIn = r_work[127:96];
    case (r_col)
      2'd0: w_colIn = r_work[127:96];
      2'd1: w_colIn = r_work[95:64];
      2'd2: w_colIn = r_work[63:32];
      2'd3: w_colIn = r_work[31:0];
      default: w_colIn = r_work[127:96];
    endcase
  end

  mix_column_word u_mixColumnWord (
    .i_column  (w_colIn),
    .i_inverse (r_mode),
    .o_column  (w_colOut)
  );

  always_comb begin
    w_workNext = r_work;
    case (r_col)
      2'd0: w_workNext[127:96] = w_colOut;
      2'd1: w_workNext[95:64]  = w_colOut;
      2'd2: w_workNext[63:32]  = w_colOut;
      2'd3: w_workNext[31:0]   = w_colOut;
      default: w_workNext = r_work;
    endcase
  end

  // out_state is a separate register so a finished result survives while
  // the working register is reused by the next transaction
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_work     <= '0;
      r_outState <= '0;
      r_mode     <= 1'b0;
      r_col      <= 2'd0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_inReady) begin
            r_work    <= in_state;
            r_mode    <= in_inverse;
            r_col     <= 2'd0;
            r_inReady <= 1'b0;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          r_work <= w_workNext;
          r_col  <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_outState <= w_workNext;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_state = r_outState;

endmodule
